gray_rom_arbiter: RTL and testbench
===================================

Name: gray_rom_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit gray-code lookup ROM (block RAM, registered address plus output register) between NUM_REQ independent requesters.
- Accepts one lookup per cycle and drives the ROM address.
- Tracks each in-flight read through a tag pipeline matched to the ROM read latency, then returns the data to the requester that issued it.
- Sits between the requesting datapaths and the ROM instance in the gray-counter design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RD_LAT, 2, ROM cycles from address on o_rom_addr to data valid on i_rom_data.

Ports:
- i_clk  input  1  system clock (200 MHz).
- i_rst_n  input  1  reset; **asynchronous, active-low**.
- i_en  input  1  global enable; low blocks new grants.
- i_req  input  NUM_REQ  per-requester lookup request, level.
- i_addr  input  8*NUM_REQ  lookup address; requester k occupies bits [8k+7:8k].
- o_gnt  output  NUM_REQ  one-hot, combinational accept strobe.
- o_rom_en  output  1  ROM read enable, registered.
- o_rom_addr  output  8  ROM address, registered.
- i_rom_data  input  8  ROM read data.
- o_rvld  output  NUM_REQ  one-hot response valid, one cycle.
- o_rdata  output  8  response data, shared by all requesters.
- o_busy  output  1  any read in flight.
- o_err  output  1  sticky data-check error (see Optional Feature).

Behaviour:
- Reset (async assert, release on clock edge):
  - o_rom_en=0, o_rom_addr=0x00, o_rvld=0, o_rdata=0x00, o_busy=0, o_err=0.
  - Round-robin pointer=0; all tag-pipeline entries invalid.
- Requester handshake:
  - Requester raises i_req[k] with i_addr[k] stable and holds both until the cycle in which o_gnt[k]=1.
  - A request is accepted at the end of that cycle.
  - The requester may keep i_req high to issue back-to-back lookups; each o_gnt cycle is one accepted lookup.
- Arbitration (combinational, cycle t):
  - If i_en=0, o_gnt=0.
  - Otherwise o_gnt selects the first set i_req bit, searching upward from the pointer and wrapping NUM_REQ-1 -> 0.
  - At most one grant per cycle.
- Pointer update: on a grant to winner w, pointer <= (w+1) mod NUM_REQ. With no grant, the pointer holds.
- Issue (edge ending cycle t): o_rom_en <= |o_gnt, and o_rom_addr <= i_addr[w] on a grant. o_rom_addr holds its value when no grant occurs.
- Tag pipeline:
  - RD_LAT+1 stages, each holding {valid, id}.
  - Stage 0 is loaded alongside o_rom_addr; stages advance every cycle with no stall.
- Response:
  - When the final stage is valid, o_rvld[id] <= 1 and o_rdata <= i_rom_data in the same edge.
  - o_rvld is therefore seen in cycle t+RD_LAT+2, i.e. grant-to-response latency RD_LAT+2 = 4 cycles at default.
  - o_rdata holds its value when o_rvld=0.
- Throughput and ordering:
  - Full rate: one grant and one response per cycle.
  - Responses return in grant order.
- o_busy = OR of all tag valid bits.
- i_en deasserted mid-operation: in-flight reads still complete and respond; only new grants stop.
- Simultaneous new request and response for the same requester: both proceed independently.
- Reset asserted mid-operation: all in-flight reads are discarded, with no o_rvld. Late ROM data is ignored.

Optional Feature:
- Macro GRAY_ARB_CHECK_EN.
- Defined:
  - Each tag stage also carries the 8-bit address.
  - On every response, compare i_rom_data against addr ^ (addr >> 1).
  - On a mismatch, set o_err=1 on the same edge as o_rvld; it stays set until reset.
- Undefined: no address storage in the tag pipeline; o_err is tied 0.

Test Plan:
1. Single lookup: requester 0, i_addr=0x05, i_en=1, ROM model with RD_LAT=2 -> o_gnt[0] in cycle t; o_rom_addr=0x05 in t+1; o_rvld[0]=1 with o_rdata=0x07 in t+4.
2. Contention: all four i_req held high from reset, addrs 0x00/0x80/0xFF/0x10 -> grants 0,1,2,3,0,... in consecutive cycles; responses 0x00, 0xC0, 0x80, 0x18 in that order to o_rvld[0..3].
3. Fairness: i_req[0] and i_req[2] held high for 10 cycles -> grants alternate 0,2,0,2; no requester granted twice in a row.
4. Enable gating: two reads granted, then i_en=0 -> o_gnt=0 immediately; both responses still arrive; o_busy falls after the last response.
5. Reset mid-flight: three reads outstanding, pulse i_rst_n low asynchronously between edges -> all outputs 0 at once; no o_rvld after release; next grant goes to requester 0.
6. GRAY_ARB_CHECK_EN defined: ROM model corrupts addr 0x3C to 0x00 (expected 0x22) -> o_err=1 coincident with that o_rvld and sticky until reset; with the macro undefined, o_err stays 0.

Source files
------------

// File: rtl/gray_rom_arbiter.sv
// gray_rom_arbiter: round-robin arbiter sharing one registered gray-code ROM
// between NUM_REQ requesters. A tag pipeline of RD_LAT+1 stages tracks each
// read so that the returned data goes back to the requester that issued it.
// Optional macro GRAY_ARB_CHECK_EN: each tag also carries the address, and
// every response is checked against addr ^ (addr >> 1). A mismatch sets the
// sticky o_err flag.
module gray_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_addr,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic                 o_rom_en,
  output logic [7:0]           o_rom_addr,
  input  logic [7:0]           i_rom_data,
  output logic [NUM_REQ-1:0]   o_rvld,
  output logic [7:0]           o_rdata,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NST = RD_LAT + 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [PW-1:0]      win_d;
  logic [7:0]         waddr_d;
  logic               any_gnt_d;

  logic               rom_en_q;
  logic [7:0]         rom_addr_q;

  logic [NST-1:0]     vld_q;
  logic [PW-1:0]      id_q [NST];
`ifdef GRAY_ARB_CHECK_EN
  logic [7:0]         tag_addr_q [NST];
  logic               err_q, err_d;
`endif

  logic [NUM_REQ-1:0] rvld_q, rvld_d;
  logic [7:0]         rdata_q;

  // Round-robin search starting at the pointer; the first set request wins.
  always_comb begin
    int unsigned idx;
    gnt_d     = '0;
    win_d     = '0;
    waddr_d   = '0;
    any_gnt_d = 1'b0;
    idx       = 0;
    if (i_en) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = (int'(ptr_q) + i) % NUM_REQ;
        if (!any_gnt_d && i_req[idx]) begin
          any_gnt_d  = 1'b1;
          gnt_d[idx] = 1'b1;
          win_d      = PW'(idx);
          waddr_d    = i_addr[8*idx +: 8];
        end
      end
    end
  end

  // Next pointer is one past the winner, wrapping; it holds without a grant.
  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt_d) begin
      ptr_d = (int'(win_d) == NUM_REQ - 1) ? '0 : win_d + PW'(1);
    end
  end

  // Decode the final tag stage into a one-hot response strobe.
  always_comb begin
    rvld_d = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rvld_d[k] = vld_q[NST-1] && (int'(id_q[NST-1]) == k);
    end
  end

`ifdef GRAY_ARB_CHECK_EN
  // The error flag is sticky and is only evaluated while a response is returning.
  always_comb begin
    err_d = err_q;
    if (vld_q[NST-1] &&
        (i_rom_data != (tag_addr_q[NST-1] ^ (tag_addr_q[NST-1] >> 1)))) begin
      err_d = 1'b1;
    end
  end
`endif

  // Issue stage: pointer, ROM enable and ROM address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rom_en_q <= any_gnt_d;
      if (any_gnt_d) begin
        rom_addr_q <= waddr_d;
      end
    end
  end

  // Tag pipeline: the tags advance every cycle and mirror the ROM read latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int unsigned s = 0; s < NST; s++) begin
        id_q[s] <= '0;
`ifdef GRAY_ARB_CHECK_EN
        tag_addr_q[s] <= '0;
`endif
      end
    end else begin
      vld_q[0] <= any_gnt_d;
      id_q[0]  <= win_d;
`ifdef GRAY_ARB_CHECK_EN
      tag_addr_q[0] <= waddr_d;
`endif
      for (int unsigned s = 1; s < NST; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
`ifdef GRAY_ARB_CHECK_EN
        tag_addr_q[s] <= tag_addr_q[s-1];
`endif
      end
    end
  end

  // Response register: the data is captured only when the final tag is valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvld_q  <= '0;
      rdata_q <= '0;
`ifdef GRAY_ARB_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      rvld_q <= rvld_d;
      if (vld_q[NST-1]) begin
        rdata_q <= i_rom_data;
      end
`ifdef GRAY_ARB_CHECK_EN
      err_q <= err_d;
`endif
    end
  end

  assign o_gnt      = gnt_d;
  assign o_rom_en   = rom_en_q;
  assign o_rom_addr = rom_addr_q;
  assign o_rvld     = rvld_q;
  assign o_rdata    = rdata_q;
  assign o_busy     = |vld_q;
`ifdef GRAY_ARB_CHECK_EN
  assign o_err      = err_q;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_gray_rom_arbiter.sv
// Directed testbench for gray_rom_arbiter (NUM_REQ=4, RD_LAT=2) with a
// two-register ROM model. The model corrupts address 0x3C so that the
// GRAY_ARB_CHECK_EN error path is exercised.
module tb_gray_rom_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic [3:0]  i_req;
  logic [31:0] i_addr;
  logic [3:0]  o_gnt;
  logic        o_rom_en;
  logic [7:0]  o_rom_addr;
  logic [7:0]  i_rom_data;
  logic [3:0]  o_rvld;
  logic [7:0]  o_rdata;
  logic        o_busy;
  logic        o_err;

  logic [7:0]  rom1, rom2;
  int          n_cmp = 0;
  int          n_bad = 0;

  gray_rom_arbiter #(.NUM_REQ(4), .RD_LAT(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_req(i_req),
    .i_addr(i_addr), .o_gnt(o_gnt), .o_rom_en(o_rom_en),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data), .o_rvld(o_rvld),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // ROM model: registered address followed by an output register.
  always @(posedge i_clk) begin
    rom1 <= (o_rom_addr == 8'h3C) ? 8'h00 : (o_rom_addr ^ (o_rom_addr >> 1));
    rom2 <= rom1;
  end
  assign i_rom_data = rom2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rom_en"}, 32'(o_rom_en), 32'h0);
    chk({tag, "_rom_addr"}, 32'(o_rom_addr), 32'h0);
    chk({tag, "_rvld"}, 32'(o_rvld), 32'h0);
    chk({tag, "_rdata"}, 32'(o_rdata), 32'h0);
    chk({tag, "_busy"}, 32'(o_busy), 32'h0);
    chk({tag, "_err"}, 32'(o_err), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req   = '0;
    #1;
    chk_idle("rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Each cycle: the inputs are driven at the falling edge and sampled 1 ns later.
  task automatic cyc();
    @(negedge i_clk);
  endtask

  logic [7:0] gray_tab [4];
  logic [3:0] exp_gnt;
  logic [3:0] exp_rvld;
  logic       exp_err;

  initial begin
    i_rst_n = 1'b0;
    i_en    = 1'b1;
    i_req   = '0;
    i_addr  = '0;
    gray_tab[0] = 8'h00; gray_tab[1] = 8'hC0; gray_tab[2] = 8'h80; gray_tab[3] = 8'h18;
`ifdef GRAY_ARB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    do_reset();

    // 1: single lookup from requester 0, address 0x05.
    cyc(); i_req = 4'b0001; i_addr[7:0] = 8'h05; #1;
    chk("t1_gnt", 32'(o_gnt), 32'h1);
    cyc(); i_req = '0; #1;
    chk("t1_rom_addr", 32'(o_rom_addr), 32'h05);
    chk("t1_rom_en", 32'(o_rom_en), 32'h1);
    chk("t1_busy", 32'(o_busy), 32'h1);
    cyc(); #1; chk("t1_rvld_t2", 32'(o_rvld), 32'h0);
    cyc(); #1; chk("t1_rvld_t3", 32'(o_rvld), 32'h0);
    cyc(); #1;
    chk("t1_rvld", 32'(o_rvld), 32'h1);
    chk("t1_rdata", 32'(o_rdata), 32'h07);
    cyc(); #1;
    chk("t1_rvld_off", 32'(o_rvld), 32'h0);
    chk("t1_rdata_hold", 32'(o_rdata), 32'h07);
    chk("t1_busy_off", 32'(o_busy), 32'h0);

    // 2: contention between all four requesters, starting from pointer 0.
    do_reset();
    i_addr = {8'h10, 8'hFF, 8'h80, 8'h00};
    for (int c = 0; c < 13; c++) begin
      cyc();
      i_req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_gnt  = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      exp_rvld = (c >= 4 && c < 12) ? 4'(1 << ((c - 4) % 4)) : 4'b0000;
      chk($sformatf("t2_gnt_c%0d", c), 32'(o_gnt), 32'(exp_gnt));
      chk($sformatf("t2_rvld_c%0d", c), 32'(o_rvld), 32'(exp_rvld));
      if (c >= 4 && c < 12)
        chk($sformatf("t2_rdata_c%0d", c), 32'(o_rdata), 32'(gray_tab[(c - 4) % 4]));
    end

    // 3: fairness between requesters 0 and 2; the pointer is 0 after test 2.
    for (int c = 0; c < 10; c++) begin
      cyc(); i_req = 4'b0101; #1;
      chk($sformatf("t3_gnt_c%0d", c), 32'(o_gnt), (c % 2 == 0) ? 32'h1 : 32'h4);
    end
    cyc(); i_req = '0;
    repeat (6) cyc();

    // 4: enable gating; the pointer is 3, so requester 0 wins twice.
    cyc(); i_req = 4'b0001; i_addr[7:0] = 8'h05; #1;
    chk("t4_gnt0", 32'(o_gnt), 32'h1);
    cyc(); i_addr[7:0] = 8'h0A; #1;
    chk("t4_gnt1", 32'(o_gnt), 32'h1);
    cyc(); i_en = 1'b0; #1;
    chk("t4_gnt_off", 32'(o_gnt), 32'h0);
    chk("t4_busy_c2", 32'(o_busy), 32'h1);
    cyc(); #1;
    chk("t4_gnt_off3", 32'(o_gnt), 32'h0);
    cyc(); #1;
    chk("t4_rvld_a", 32'(o_rvld), 32'h1);
    chk("t4_rdata_a", 32'(o_rdata), 32'h07);
    chk("t4_busy_c4", 32'(o_busy), 32'h1);
    cyc(); #1;
    chk("t4_rvld_b", 32'(o_rvld), 32'h1);
    chk("t4_rdata_b", 32'(o_rdata), 32'h0F);
    chk("t4_busy_c5", 32'(o_busy), 32'h0);
    cyc(); i_req = '0; i_en = 1'b1; #1;
    chk("t4_rvld_off", 32'(o_rvld), 32'h0);

    // 5: asynchronous reset while three reads of requester 1 are in flight.
    i_addr[15:8] = 8'h33;
    for (int c = 0; c < 3; c++) begin
      cyc(); i_req = 4'b0010; #1;
      chk($sformatf("t5_gnt_c%0d", c), 32'(o_gnt), 32'h2);
    end
    cyc(); i_req = '0; #1;
    chk("t5_busy_pre", 32'(o_busy), 32'h1);
    #1 i_rst_n = 1'b0;
    #1 chk_idle("t5_async");
    cyc(); i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc(); #1;
      chk($sformatf("t5_rvld_c%0d", c), 32'(o_rvld), 32'h0);
      chk($sformatf("t5_busy_c%0d", c), 32'(o_busy), 32'h0);
    end
    cyc(); i_req = 4'b1111; #1;
    chk("t5_gnt_after", 32'(o_gnt), 32'h1);
    cyc(); i_req = '0;
    repeat (6) cyc();

    // 6: data check on corrupted address 0x3C (the pointer is 1, requester 0 wins).
    cyc(); i_req = 4'b0001; i_addr[7:0] = 8'h3C; #1;
    chk("t6_gnt", 32'(o_gnt), 32'h1);
    cyc(); i_req = '0; #1;
    chk("t6_err_early", 32'(o_err), 32'h0);
    cyc(); cyc(); #1;
    chk("t6_err_pre", 32'(o_err), 32'h0);
    cyc(); #1;
    chk("t6_rvld", 32'(o_rvld), 32'h1);
    chk("t6_rdata", 32'(o_rdata), 32'h00);
    chk("t6_err", 32'(o_err), 32'(exp_err));
    repeat (3) cyc();
    #1 chk("t6_err_sticky", 32'(o_err), 32'(exp_err));
    do_reset();
    #1 chk("t6_err_cleared", 32'(o_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
